// File: rtl/nios2_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nios2_mul_pkg
//  Brief    : Shared encodings for the Nios II multi-cycle multiply sequencer:
//             op codes, FSM states and partial-product index/shift constants.
//  Revision : 1.0 - initial release
// ============================================================================
package nios2_mul_pkg;

    // Custom-instruction op codes
    localparam logic [1:0] OP_MUL    = 2'd0;  // low word of A*B
    localparam logic [1:0] OP_MULXUU = 2'd1;  // high word, unsigned x unsigned
    localparam logic [1:0] OP_MULXSS = 2'd2;  // high word, signed x signed
    localparam logic [1:0] OP_MULXSU = 2'd3;  // high word, signed x unsigned

    // Sequencer FSM states
    localparam int         ST_W     = 3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_ACC   = 3'd2;
    localparam logic [2:0] ST_FIX   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Partial-product issue order; bit 1 selects A half, bit 0 selects B half
    localparam logic [1:0] PP_LL = 2'd0;  // A.lo * B.lo
    localparam logic [1:0] PP_LH = 2'd1;  // A.lo * B.hi
    localparam logic [1:0] PP_HL = 2'd2;  // A.hi * B.lo
    localparam logic [1:0] PP_HH = 2'd3;  // A.hi * B.hi

    // Left shift of each partial product, expressed in half-words
    function automatic int unsigned pp_shift_halves(input logic [1:0] idx);
        case (idx)
            PP_LL:        return 32'd0;
            PP_LH, PP_HL: return 32'd1;
            default:      return 32'd2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios2_mul16_cell.sv
`default_nettype none
// ============================================================================
//  Module   : nios2_mul16_cell
//  Brief    : Registered HALF_W x HALF_W unsigned multiplier with clock
//             enable and synchronous clear. One-cycle latency.
//  Revision : 1.0 - initial release
// ============================================================================
module nios2_mul16_cell #(
    parameter int HALF_W = 16
) (
    input  logic                  clk,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [HALF_W-1:0]     a_i,
    input  logic [HALF_W-1:0]     b_i,
    output logic [2*HALF_W-1:0]   p_o
);

    logic [2*HALF_W-1:0] p_q;

    // Product register: clear wins over enable so a kill never leaks a stale product
    always_ff @(posedge clk) begin
        if (clr_i) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= {{HALF_W{1'b0}}, a_i} * {{HALF_W{1'b0}}, b_i};
        end
    end

    assign p_o = p_q;

endmodule
`default_nettype wire

// File: rtl/nios2_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : nios2_mul_sequencer
//  Brief    : Multi-cycle 32x32 multiply for the Nios II custom-datapath slot.
//             One registered half-width multiplier cell is time-shared over the
//             partial products, which are accumulated into a double-width sum.
//             MUL returns the low word; MULXUU/MULXSS/MULXSU return the high
//             word after a signed correction of the unsigned product.
//  Revision : 1.0 - initial release
// ============================================================================
module nios2_mul_sequencer
    import nios2_mul_pkg::*;
#(
    parameter int DATA_W = 32,   // even and >= 8
    parameter int OP_W   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [OP_W-1:0]   in_op_i,
    input  logic [DATA_W-1:0] in_src1_i,
    input  logic [DATA_W-1:0] in_src2_i,
    input  logic              abort_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_result_o,
    output logic              busy_o
);

    localparam int HALF_W = DATA_W / 2;
    localparam int ACC_W  = 2 * DATA_W;

    localparam logic [OP_W-1:0] c_OP_MUL    = OP_W'(OP_MUL);
    localparam logic [OP_W-1:0] c_OP_MULXSS = OP_W'(OP_MULXSS);
    localparam logic [OP_W-1:0] c_OP_MULXSU = OP_W'(OP_MULXSU);

    logic [ST_W-1:0]   state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] src1_q, src2_q;
    logic              pvld_q;      // cell output holds a fresh product
    logic [1:0]        pidx_q;      // which pair that product belongs to

    logic              w_accept;
    logic              w_cell_en;
    logic              w_cell_clr;
    logic [HALF_W-1:0] w_cell_a;
    logic [HALF_W-1:0] w_cell_b;
    logic [DATA_W-1:0] w_pp;
    logic [ACC_W-1:0]  w_pp_shifted;
    logic [1:0]        w_last_idx;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_corr;
    logic [DATA_W-1:0] w_result;

    assign in_ready_o   = (state_q == ST_IDLE) & ~abort_i;
    assign busy_o       = (state_q != ST_IDLE);
    assign out_valid_o  = (state_q == ST_DONE);
    assign out_result_o = res_q;

    assign w_accept   = in_valid_i & in_ready_o;
    assign w_cell_en  = (state_q == ST_ISSUE);
    assign w_cell_clr = ~reset_n | abort_i;
    assign w_cell_a   = idx_q[1] ? src1_q[DATA_W-1:HALF_W] : src1_q[HALF_W-1:0];
    assign w_cell_b   = idx_q[0] ? src2_q[DATA_W-1:HALF_W] : src2_q[HALF_W-1:0];

    // MUL never needs A.hi*B.hi: it only contributes above the low word
    assign w_last_idx = (op_q == c_OP_MUL) ? PP_HL : PP_HH;

    assign w_pp_shifted = {{DATA_W{1'b0}}, w_pp} << (pp_shift_halves(pidx_q) * HALF_W);

    nios2_mul16_cell #(
        .HALF_W (HALF_W)
    ) u_cell (
        .clk   (clk),
        .clr_i (w_cell_clr),
        .en_i  (w_cell_en),
        .a_i   (w_cell_a),
        .b_i   (w_cell_b),
        .p_o   (w_pp)
    );

    // Signed correction: unsigned product minus B when A<0 and minus A when B<0
    always_comb begin
        w_hi   = acc_q[ACC_W-1:DATA_W];
        w_corr = '0;
        case (op_q)
            c_OP_MULXSS: w_corr = (src1_q[DATA_W-1] ? src2_q : '0)
                                + (src2_q[DATA_W-1] ? src1_q : '0);
            c_OP_MULXSU: w_corr = (src1_q[DATA_W-1] ? src2_q : '0);
            default:     w_corr = '0;
        endcase
        w_result = (op_q == c_OP_MUL) ? acc_q[DATA_W-1:0] : (w_hi - w_corr);
    end

    // Next-state logic: sequence the pairs, accumulate whatever the cell produced
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        res_d   = res_q;
        if (pvld_q) begin
            acc_d = acc_q + w_pp_shifted;
        end
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_ISSUE;
                    idx_d   = PP_LL;
                    acc_d   = '0;
                end
            end
            ST_ISSUE: begin
                if (idx_q == w_last_idx) begin
                    state_d = ST_ACC;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_ACC: begin
                state_d = ST_FIX;
            end
            ST_FIX: begin
                res_d   = w_result;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers: reset first, then abort, which kills the op but keeps the last result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            pvld_q  <= 1'b0;
            pidx_q  <= '0;
        end else if (abort_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            pvld_q  <= 1'b0;
            pidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            pvld_q  <= w_cell_en;
            pidx_q  <= idx_q;
            if (w_accept) begin
                op_q   <= in_op_i;
                src1_q <= in_src1_i;
                src2_q <= in_src2_i;
            end
        end
    end

endmodule
`default_nettype wire
